// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL bus types and constants shared by the CSR host
package tlul_pkg;

  parameter int TL_AW  = 32;
  parameter int TL_DW  = 32;
  parameter int TL_AIW = 8;
  parameter int TL_DIW = 1;
  parameter int TL_SZW = 2;
  parameter int TL_DBW = 4;

  parameter logic [2:0] PutFullData    = 3'h0;
  parameter logic [2:0] PutPartialData = 3'h1;
  parameter logic [2:0] Get            = 3'h4;

  parameter logic [3:0] MuBi4False = 4'h9;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    tl_d_user_t        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// rtl/tlul_cmd_intg_gen.sv - fills A-channel command and data integrity fields
module tlul_cmd_intg_gen (
  input  tlul_pkg::tl_h2d_t tl_i,
  output tlul_pkg::tl_h2d_t tl_o
);

  // Seven check bits, each the parity of every seventh payload bit.
  function automatic logic [6:0] fold7(input logic [63:0] v);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[i % 7] = r[i % 7] ^ v[i];
    end
    return r;
  endfunction

  logic [42:0] w_cmd;

  assign w_cmd = {tl_i.a_user.instr_type, tl_i.a_address, tl_i.a_opcode, tl_i.a_mask};

  // Pass the request through, overriding only the integrity fields.
  always_comb begin
    tl_o                    = tl_i;
    tl_o.a_user.cmd_intg    = fold7({21'b0, w_cmd});
    tl_o.a_user.data_intg   = fold7({32'b0, tl_i.a_data});
  end

endmodule

// File: rtl/tlul_csr_host.sv
// rtl/tlul_csr_host.sv - single-outstanding TL-UL CSR initiator with read polling
module tlul_csr_host #(
  parameter logic [tlul_pkg::TL_AIW-1:0] SourceId = '0,
  parameter int PollGap     = 4,
  parameter int PollTimeout = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic                      req_poll_i,
  input  logic [tlul_pkg::TL_AW-1:0] req_addr_i,
  input  logic [31:0]               req_wdata_i,
  input  logic [31:0]               req_mask_i,
  input  logic [3:0]                req_be_i,
  output logic                      rsp_valid_o,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output tlul_pkg::tl_h2d_t         tl_o,
  input  tlul_pkg::tl_d2h_t         tl_i
);

  localparam int AW   = tlul_pkg::TL_AW;
  localparam int CntW = $clog2(PollTimeout + 1);
  localparam int GapW = (PollGap > 1) ? $clog2(PollGap) : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(PollTimeout);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]      r_state;
  logic            r_we;
  logic            r_poll;
  logic [AW-3:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mask;
  logic [3:0]      r_be;
  logic [CntW-1:0] r_attempts;
  logic [GapW-1:0] r_gap_cnt;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic            r_timeout;

  logic [CntW-1:0]   w_attempt_next;
  logic              w_match;
  logic              w_finish;
  tlul_pkg::tl_h2d_t w_tl_raw;
  logic              w_unused_in;

  assign w_attempt_next = r_attempts + 1'b1;
  assign w_match        = ((tl_i.d_data & r_mask) == (r_wdata & r_mask));
  // Writes, plain reads, bus errors and poll hits all end the transaction.
  assign w_finish       = r_we || !r_poll || tl_i.d_error || w_match;

  assign req_ready_o   = (r_state == S_IDLE);
  assign rsp_valid_o   = (r_state == S_DONE);
  assign rsp_rdata_o   = r_rdata;
  assign rsp_err_o     = r_err;
  assign rsp_timeout_o = r_timeout;

  // Response-side fields and the low address bits are not needed by this host.
  assign w_unused_in = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                         tl_i.d_sink, tl_i.d_user, req_addr_i[1:0]};

  // Request capture, transaction sequencing, poll retry and result latching.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_poll     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
      r_be       <= '0;
      r_attempts <= '0;
      r_gap_cnt  <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_we       <= req_we_i;
            r_poll     <= req_poll_i && !req_we_i;
            r_addr     <= req_addr_i[AW-1:2];
            r_wdata    <= req_wdata_i;
            r_mask     <= req_mask_i;
            r_be       <= req_be_i;
            r_attempts <= '0;
            r_timeout  <= 1'b0;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (tl_i.a_ready) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (tl_i.d_valid) begin
            r_attempts <= w_attempt_next;
            if (w_finish) begin
              r_rdata <= tl_i.d_data;
              r_err   <= tl_i.d_error;
              r_state <= S_DONE;
            end else if (w_attempt_next == TimeoutVal) begin
              r_rdata   <= tl_i.d_data;
              r_err     <= tl_i.d_error;
              r_timeout <= 1'b1;
              r_state   <= S_DONE;
            end else if (PollGap > 0) begin
              r_gap_cnt <= GapW'(PollGap - 1);
              r_state   <= S_GAP;
            end else begin
              r_state <= S_ADDR;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_ADDR;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A-channel fields decode only from state and captured request, never from tl_i.
  always_comb begin
    w_tl_raw                   = '0;
    w_tl_raw.a_valid           = (r_state == S_ADDR);
    w_tl_raw.a_opcode          = !r_we ? tlul_pkg::Get :
                                 (r_be == 4'hF) ? tlul_pkg::PutFullData :
                                                  tlul_pkg::PutPartialData;
    w_tl_raw.a_param           = 3'd0;
    w_tl_raw.a_size            = 2'd2;
    w_tl_raw.a_source          = SourceId;
    w_tl_raw.a_address         = {r_addr, 2'b00};
    w_tl_raw.a_mask            = r_we ? r_be : 4'hF;
    w_tl_raw.a_data            = r_we ? r_wdata : 32'h0;
    w_tl_raw.a_user.instr_type = tlul_pkg::MuBi4False;
    w_tl_raw.d_ready           = (r_state == S_RESP);
  end

  tlul_cmd_intg_gen u_intg (
    .tl_i (w_tl_raw),
    .tl_o (tl_o)
  );

endmodule

// File: tb/tb_tlul_csr_host.sv
// tb/tb_tlul_csr_host.sv - directed scoreboard bench for tlul_csr_host
module tb_tlul_csr_host;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    bit          chk_data;
  } a_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } r_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_poll = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_mask = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  tlul_pkg::tl_h2d_t tl_o;
  tlul_pkg::tl_d2h_t tl_i = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  a_exp_t      exp_a[$];
  r_exp_t      exp_r[$];
  logic [31:0] rq[$];
  int          hs_cyc[$];

  int  stall_left = 0;
  int  stalled_n = 0;
  bit  d_hold = 0;
  bit  d_err_cfg = 0;
  int  rsp_seen = 0;
  int  rsp_cyc = 0;
  bit  last_a_hs = 0;
  bit  last_d_hs = 0;
  bit  snap_vld = 0;
  tlul_pkg::tl_h2d_t snap;

  tlul_csr_host #(.SourceId(8'd0), .PollGap(4), .PollTimeout(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_we_i      (req_we),
    .req_poll_i    (req_poll),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_mask_i    (req_mask),
    .req_be_i      (req_be),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .rsp_timeout_o (rsp_timeout),
    .tl_o          (tl_o),
    .tl_i          (tl_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Responder and monitors: inputs for the next rising edge are set here.
  always @(negedge clk) begin
    if (!rst_n) begin
      tl_i       = '0;
      tl_i.a_ready = 1'b1;
      last_a_hs  = 0;
      last_d_hs  = 0;
      snap_vld   = 0;
      stall_left = 0;
    end else begin
      if (last_d_hs) tl_i.d_valid = 1'b0;
      if (last_a_hs && !d_hold) begin
        tl_i.d_valid = 1'b1;
        tl_i.d_data  = (rq.size() > 0) ? rq.pop_front() : 32'h0;
        tl_i.d_error = d_err_cfg;
      end
      if (snap_vld) begin
        check("a_valid_held", tl_o.a_valid, 1);
        check("a_fields_stable", (tl_o === snap), 1);
      end
      if (tl_o.a_valid) begin
        if (stall_left > 0) begin
          tl_i.a_ready = 1'b0;
          stall_left--;
          stalled_n++;
          snap = tl_o;
          snap_vld = 1;
        end else begin
          a_exp_t e;
          tl_i.a_ready = 1'b1;
          snap_vld = 0;
          hs_cyc.push_back(cyc);
          if (exp_a.size() == 0) begin
            check("a_unexpected", 1, 0);
          end else begin
            e = exp_a.pop_front();
            check("a_opcode", tl_o.a_opcode, e.op);
            check("a_address", tl_o.a_address, e.addr);
            check("a_mask", tl_o.a_mask, e.mask);
            if (e.chk_data) check("a_data", tl_o.a_data, e.data);
            check("a_size", tl_o.a_size, 2);
            check("a_param", tl_o.a_param, 0);
            check("a_source", tl_o.a_source, 0);
            check("a_instr_type", tl_o.a_user.instr_type, 4'h9);
          end
        end
      end else begin
        tl_i.a_ready = 1'b1;
      end
      last_a_hs = tl_o.a_valid && tl_i.a_ready;
      last_d_hs = tl_i.d_valid && tl_o.d_ready;
      if (rsp_valid) begin
        rsp_seen++;
        rsp_cyc = cyc;
        if (exp_r.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          r_exp_t r;
          r = exp_r.pop_front();
          check("rsp_rdata", rsp_rdata, r.rdata);
          check("rsp_err", rsp_err, r.err);
          check("rsp_timeout", rsp_timeout, r.tmo);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_a(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input bit chk);
    a_exp_t e;
    e.op = op; e.addr = addr; e.mask = mask; e.data = data; e.chk_data = chk;
    exp_a.push_back(e);
  endtask

  task automatic push_r(input logic [31:0] rdata, input logic err, input logic tmo);
    r_exp_t r;
    r.rdata = rdata; r.err = err; r.tmo = tmo;
    exp_r.push_back(r);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, req_ready, 1);
    check({pfx, "_a_valid"}, tl_o.a_valid, 0);
    check({pfx, "_d_ready"}, tl_o.d_ready, 0);
    check({pfx, "_rsp_valid"}, rsp_valid, 0);
    check({pfx, "_rsp_rdata"}, rsp_rdata, 0);
    check({pfx, "_rsp_err"}, rsp_err, 0);
    check({pfx, "_rsp_timeout"}, rsp_timeout, 0);
  endtask

  task automatic issue(input logic we, input logic poll, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] mask,
                       input logic [3:0] be, output int lat);
    int c0;
    int s0;
    int n;
    req_valid = 1'b1; req_we = we; req_poll = poll; req_addr = addr;
    req_wdata = wdata; req_mask = mask; req_be = be;
    c0 = cyc;
    s0 = rsp_seen;
    hs_cyc.delete();
    step();
    req_valid = 1'b0;
    req_we = 1'($urandom); req_poll = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_mask = $urandom; req_be = 4'($urandom);
    check("busy_after_accept", req_ready, 0);
    check("timeout_clr_on_accept", rsp_timeout, 0);
    n = 0;
    while (rsp_seen == s0 && n < 300) begin
      step();
      n++;
    end
    check("rsp_arrived", (rsp_seen != s0), 1);
    lat = rsp_cyc - c0;
    step();
    check("ready_after_done", req_ready, 1);
  endtask

  initial begin
    int lat;
    int n;

    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Full-word write.
    push_a(3'd0, 32'h10, 4'hF, 32'hDEADBEEF, 1);
    push_r(32'h0, 0, 0);
    issue(1, 0, 32'h10, 32'hDEADBEEF, 32'h0, 4'hF, lat);
    check("wr_full_latency", lat, 3);

    // Partial write.
    push_a(3'd1, 32'h24, 4'b0011, 32'hA5A50F0F, 1);
    push_r(32'h0, 0, 0);
    issue(1, 0, 32'h24, 32'hA5A50F0F, 32'h0, 4'b0011, lat);
    check("wr_part_latency", lat, 3);

    // Unaligned read address is word-aligned on the bus.
    rq.push_back(32'h12345678);
    push_a(3'd4, 32'h10, 4'hF, 32'h0, 0);
    push_r(32'h12345678, 0, 0);
    issue(0, 0, 32'h13, 32'h0, 32'h0, 4'h0, lat);
    check("rd_latency", lat, 3);

    // Poll hits on the third attempt.
    rq.push_back(32'h0); rq.push_back(32'h0); rq.push_back(32'h1);
    for (int i = 0; i < 3; i++) push_a(3'd4, 32'h20, 4'hF, 32'h0, 0);
    push_r(32'h1, 0, 0);
    issue(0, 1, 32'h20, 32'h1, 32'h1, 4'h0, lat);
    check("poll_hit_gets", hs_cyc.size(), 3);
    for (int i = 1; i < hs_cyc.size(); i++) check("poll_period", hs_cyc[i] - hs_cyc[i-1], 6);

    // Poll never matches: timeout after four attempts.
    for (int i = 0; i < 4; i++) begin
      rq.push_back(32'h2);
      push_a(3'd4, 32'h20, 4'hF, 32'h0, 0);
    end
    push_r(32'h2, 0, 1);
    issue(0, 1, 32'h20, 32'h1, 32'h1, 4'h0, lat);
    check("poll_tmo_gets", hs_cyc.size(), 4);
    check("timeout_hold", rsp_timeout, 1);

    // a_ready withheld for five cycles.
    stall_left = 5;
    stalled_n = 0;
    rq.push_back(32'hCAFEF00D);
    push_a(3'd4, 32'h40, 4'hF, 32'h0, 0);
    push_r(32'hCAFEF00D, 0, 0);
    issue(0, 0, 32'h40, 32'h0, 32'h0, 4'h0, lat);
    check("stall_cycles", stalled_n, 5);
    check("stall_latency", lat, 8);
    check("stall_one_get", hs_cyc.size(), 1);

    // Bus error during a poll ends it without retry.
    d_err_cfg = 1;
    rq.push_back(32'h5A5A0000);
    push_a(3'd4, 32'h30, 4'hF, 32'h0, 0);
    push_r(32'h5A5A0000, 1, 0);
    issue(0, 1, 32'h30, 32'h1, 32'h1, 4'h0, lat);
    d_err_cfg = 0;
    check("err_one_get", hs_cyc.size(), 1);
    check("err_latency", lat, 3);

    // Reset while waiting for the response.
    d_hold = 1;
    push_a(3'd4, 32'h50, 4'hF, 32'h0, 0);
    req_valid = 1'b1; req_we = 1'b0; req_poll = 1'b0; req_addr = 32'h51;
    step();
    req_valid = 1'b0;
    n = 0;
    while (!tl_o.d_ready && n < 20) begin
      step();
      n++;
    end
    check("reached_resp", tl_o.d_ready, 1);
    check("pre_reset_err", rsp_err, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    step();
    rst_n = 1'b1;
    d_hold = 0;
    step();

    // Block is usable again after reset.
    push_a(3'd1, 32'h8, 4'hC, 32'h11223344, 1);
    push_r(32'h0, 0, 0);
    issue(1, 0, 32'h8, 32'h11223344, 32'h0, 4'hC, lat);
    check("post_reset_latency", lat, 3);

    repeat (3) step();
    check("exp_a_drained", exp_a.size(), 0);
    check("exp_r_drained", exp_r.size(), 0);
    check("rq_drained", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tlul_csr_host.md
# tlul_csr_host

TL-UL host (initiator) that turns single-word CSR requests from a local sequencer or boot controller into TL-UL transactions. It is the requesting end of the register bus served by the DDR PHY's TL-UL register adapter. Only one transaction is outstanding at a time. Optionally, a read can poll a register until a masked compare matches, with a programmable gap between attempts and an attempt-count timeout. It sits in the `clk_sys` domain, between PHY/controller bring-up logic and the TL-UL crossbar or PHY `tl_i`/`tl_o` pair.

## Interface
Parameters:
- `SourceId`, default 0: value driven on `a_source` for every request.
- `PollGap`, default 4: idle cycles between poll attempts; 0 is legal (no gap).
- `PollTimeout`, default 1024: maximum poll attempts, at least 1.

Ports:
- `clk_i`, in, 1: clock. One clock.
- `rst_ni`, in, 1: reset. Asynchronous and active-low.
- `req_valid_i`, in, 1: request valid.
- `req_ready_o`, out, 1: high only in IDLE.
- `req_we_i`, in, 1: 1 = write, 0 = read.
- `req_poll_i`, in, 1: read poll enable; ignored when `req_we_i`=1.
- `req_addr_i`, in, `TL_AW`: byte address; bits [1:0] are forced to 0 on the bus.
- `req_wdata_i`, in, 32: write data, or poll compare value.
- `req_mask_i`, in, 32: poll compare mask.
- `req_be_i`, in, 4: write byte enables.
- `rsp_valid_o`, out, 1: one-cycle pulse when a request completes.
- `rsp_rdata_o`, out, 32: last `d_data` received.
- `rsp_err_o`, out, 1: `d_error` of the last response.
- `rsp_timeout_o`, out, 1: poll exhausted `PollTimeout` attempts.
- `tl_o`, out, `tlul_pkg::tl_h2d_t`: A channel plus `d_ready`.
- `tl_i`, in, `tlul_pkg::tl_d2h_t`: D channel plus `a_ready`.

## Operation
- The request is captured into internal registers on `req_valid_i && req_ready_o`. Inputs are don't-care afterwards.
- A-channel encoding:
  - Read: `a_opcode`=Get (4), `a_mask`=4'hF.
  - Write with `be`=4'hF: PutFullData (0).
  - Write with any other `be`: PutPartialData (1), `a_mask`=`be`.
  - Always: `a_size`=2, `a_param`=0, `a_source`=`SourceId`.
  - `a_user` integrity comes from a `tlul_cmd_intg_gen` instance.
  - `a_user` instruction type is MuBi4False (data access).
- FSM states: IDLE, ADDR, RESP, GAP, DONE.
  - IDLE→ADDR on request accept.
  - ADDR drives `a_valid`=1, with all A fields stable. ADDR→RESP on `a_ready`.
  - RESP drives `d_ready`=1. On `d_valid`, the block latches `d_data` and `d_error`, then applies the first matching rule below.
    - Write, non-poll read, or `d_error`=1 → DONE.
    - Poll and `(d_data & mask)==(wdata & mask)` → DONE.
    - Poll mismatch with attempt count = `PollTimeout` → DONE, `rsp_timeout_o`=1.
    - Otherwise, attempt count +1: → GAP if `PollGap`>0, else → ADDR.
  - GAP counts down `PollGap` cycles, then → ADDR.
  - DONE: `rsp_valid_o`=1 for one cycle, → IDLE.
- The attempt counter is cleared on accept. It counts completed reads, so 1 = first response.
- `rsp_rdata_o`, `rsp_err_o` and `rsp_timeout_o` hold until the next completion. `rsp_timeout_o` is cleared on accept.
- `d_valid` outside RESP is not consumed, since `d_ready`=0. The responder holds it.

## Timing
- Reset values: state IDLE; `req_ready_o`=1, `a_valid`=0, `d_ready`=0; `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `rsp_timeout_o`=0; counters 0.
- All `tl_o` fields are registered or decoded only from state and captured registers. There is no combinational path from `tl_i` to `tl_o`.
- Minimum latency, with the responder asserting `a_ready` and returning `d_valid` on the next cycle:
  - Cycle 0: accept.
  - Cycle 1: `a_valid`.
  - Cycle 2: `d_valid`.
  - Cycle 3: `rsp_valid_o`.
- A new accept is possible in cycle 4.
- Poll attempt period is 2 + `PollGap` cycles at minimum.
- `a_valid` must never drop before `a_ready` is seen.
- Reset asserted mid-operation: the block immediately returns to IDLE with all outputs at reset values. The responder is in the same reset domain.

## Test plan
- Write `addr`=0x10, `wdata`=0xDEADBEEF, `be`=4'hF → one PutFullData beat, `a_mask`=F; `rsp_valid_o` pulse 3 cycles after accept, `rsp_err_o`=0.
- Write with `be`=4'b0011 → `a_opcode`=1, `a_mask`=4'b0011.
- Read `addr`=0x13 → Get to 0x10, `a_mask`=F; `rsp_rdata_o` equals the returned `d_data` (0x12345678).
- Poll with `mask`=0x1, value 0x1; responder returns 0, 0, 1 → exactly 3 Gets, each 4 idle cycles apart; completion with `rsp_rdata_o`=1, `rsp_timeout_o`=0.
- Poll with `PollTimeout`=4 and responder always returning 0 → 4 Gets, then `rsp_timeout_o`=1 alongside the `rsp_valid_o` pulse.
- `a_ready` held low 5 cycles → `a_valid` and fields stable throughout, one transaction issued. `d_error`=1 on a poll → immediate completion, `rsp_err_o`=1, no retry. `rst_ni` pulsed while in RESP → all outputs return to reset values.
